// File: rtl/usb_fs_rx_router.sv
// Routes decoded USB full-speed receive packets into token, payload and handshake events.
// Optional SOF reporting is enabled by defining USB_RX_ROUTER_SOF_EN.
module usb_fs_rx_router #(
    parameter int TIMEOUT_CYCLES = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  dev_addr,
    input  logic        rx_pkt_start,
    input  logic        rx_pkt_end,
    input  logic        rx_pkt_valid,
    input  logic [3:0]  rx_pid,
    input  logic [6:0]  rx_addr,
    input  logic [3:0]  rx_endp,
    input  logic [10:0] rx_frame_num,
    input  logic        rx_data_put,
    input  logic [7:0]  rx_data,
    output logic        in_token,
    output logic [3:0]  in_endp,
    output logic        in_ack,
    output logic        out_token,
    output logic        out_setup,
    output logic [3:0]  out_endp,
    output logic        out_data_put,
    output logic [7:0]  out_data,
    output logic        out_data_pid,
    output logic        out_pkt_end,
    output logic        out_pkt_valid,
    output logic        timeout,
    output logic        sof,
    output logic [10:0] frame_num
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SOF   = 4'b0101;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;

    typedef enum logic [1:0] {IDLE, WAIT_DATA, DATA, WAIT_HS} state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    logic good_end;
    logic addr_hit;
    logic tok_out;
    logic tok_in;
    logic token_pid;

    assign good_end  = rx_pkt_end & rx_pkt_valid;
    assign addr_hit  = (rx_addr == dev_addr);
    assign tok_out   = good_end & addr_hit & ((rx_pid == PID_OUT) | (rx_pid == PID_SETUP));
    assign tok_in    = good_end & addr_hit & (rx_pid == PID_IN);
    // All token PIDs end in 01; such packets never terminate a handshake wait.
    assign token_pid = (rx_pid[1:0] == 2'b01);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            in_token      <= 1'b0;
            in_endp       <= 4'd0;
            in_ack        <= 1'b0;
            out_token     <= 1'b0;
            out_setup     <= 1'b0;
            out_endp      <= 4'd0;
            out_data_put  <= 1'b0;
            out_data      <= 8'd0;
            out_data_pid  <= 1'b0;
            out_pkt_end   <= 1'b0;
            out_pkt_valid <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            in_token      <= 1'b0;
            in_ack        <= 1'b0;
            out_token     <= 1'b0;
            out_data_put  <= 1'b0;
            out_pkt_end   <= 1'b0;
            out_pkt_valid <= 1'b0;
            timeout       <= 1'b0;
            if (tok_out) begin
                out_token <= 1'b1;
                out_setup <= (rx_pid == PID_SETUP);
                out_endp  <= rx_endp;
                state     <= WAIT_DATA;
                cnt       <= '0;
            end else if (tok_in) begin
                in_token <= 1'b1;
                in_endp  <= rx_endp;
                state    <= WAIT_HS;
                cnt      <= '0;
            end else begin
                case (state)
                    WAIT_DATA: begin
                        if (rx_pkt_start) begin
                            state <= DATA;
                        end else if (cnt == CNT_LAST) begin
                            timeout <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (rx_data_put) begin
                            out_data_put <= 1'b1;
                            out_data     <= rx_data;
                        end
                        if (rx_pkt_end) begin
                            out_pkt_end   <= 1'b1;
                            out_pkt_valid <= rx_pkt_valid & ((rx_pid == PID_DATA0) | (rx_pid == PID_DATA1));
                            out_data_pid  <= rx_pid[3];
                            state         <= IDLE;
                        end else if (rx_pkt_start) begin
                            // A new packet began before the previous one ended: flag it bad, keep receiving.
                            out_pkt_end   <= 1'b1;
                            out_pkt_valid <= 1'b0;
                        end
                    end
                    WAIT_HS: begin
                        if (rx_pkt_end && !token_pid) begin
                            in_ack <= good_end & (rx_pid == PID_ACK);
                            state  <= IDLE;
                        end else if (rx_pkt_start) begin
                            cnt <= '0;
                        end else if (cnt == CNT_LAST) begin
                            timeout <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef USB_RX_ROUTER_SOF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            sof       <= 1'b0;
            frame_num <= 11'd0;
        end else begin
            sof <= 1'b0;
            if (good_end && rx_pid == PID_SOF) begin
                sof       <= 1'b1;
                frame_num <= rx_frame_num;
            end
        end
    end
`else
    logic unused_frame;
    assign unused_frame = ^rx_frame_num;
    assign sof          = 1'b0;
    assign frame_num    = 11'd0;
`endif

endmodule

// File: tb/tb_usb_fs_rx_router.sv
// Directed bench for usb_fs_rx_router: expected output events are queued by the stimulus
// and popped by an independent monitor on the falling clock edge.
module tb_usb_fs_rx_router;

    localparam int W = 16;
    localparam logic [3:0] K_IN   = 4'd1;
    localparam logic [3:0] K_ACK  = 4'd2;
    localparam logic [3:0] K_OUT  = 4'd3;
    localparam logic [3:0] K_DATA = 4'd4;
    localparam logic [3:0] K_END  = 4'd5;
    localparam logic [3:0] K_TMO  = 4'd6;
    localparam logic [3:0] K_SOF  = 4'd7;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SOF   = 4'b0101;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;

    logic        clk;
    logic        reset;
    logic [6:0]  dev_addr;
    logic        rx_pkt_start;
    logic        rx_pkt_end;
    logic        rx_pkt_valid;
    logic [3:0]  rx_pid;
    logic [6:0]  rx_addr;
    logic [3:0]  rx_endp;
    logic [10:0] rx_frame_num;
    logic        rx_data_put;
    logic [7:0]  rx_data;
    logic        in_token;
    logic [3:0]  in_endp;
    logic        in_ack;
    logic        out_token;
    logic        out_setup;
    logic [3:0]  out_endp;
    logic        out_data_put;
    logic [7:0]  out_data;
    logic        out_data_pid;
    logic        out_pkt_end;
    logic        out_pkt_valid;
    logic        timeout;
    logic        sof;
    logic [10:0] frame_num;

    logic [W-1:0] exp_q[$];
    int n_pass = 0;
    int n_total = 0;

    usb_fs_rx_router #(.TIMEOUT_CYCLES(512)) dut (
        .clk(clk), .reset(reset), .dev_addr(dev_addr),
        .rx_pkt_start(rx_pkt_start), .rx_pkt_end(rx_pkt_end), .rx_pkt_valid(rx_pkt_valid),
        .rx_pid(rx_pid), .rx_addr(rx_addr), .rx_endp(rx_endp), .rx_frame_num(rx_frame_num),
        .rx_data_put(rx_data_put), .rx_data(rx_data),
        .in_token(in_token), .in_endp(in_endp), .in_ack(in_ack),
        .out_token(out_token), .out_setup(out_setup), .out_endp(out_endp),
        .out_data_put(out_data_put), .out_data(out_data), .out_data_pid(out_data_pid),
        .out_pkt_end(out_pkt_end), .out_pkt_valid(out_pkt_valid),
        .timeout(timeout), .sof(sof), .frame_num(frame_num)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] all_out();
        return {27'd0, in_token, in_endp, in_ack, out_token, out_setup, out_endp,
                out_data_put, out_data, out_data_pid, out_pkt_end, out_pkt_valid,
                timeout, sof, frame_num};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, got, want);
    endtask

    task automatic expect_ev(input logic [3:0] k, input logic [11:0] p);
        exp_q.push_back({k, p});
    endtask

    // Scoreboard monitor
    task automatic observe(input logic [3:0] k, input logic [11:0] p, input string name);
        logic [W-1:0] want;
        n_total++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s unexpected event: got %0h want none", name, {k, p});
        end else begin
            want = exp_q.pop_front();
            if (want === {k, p}) n_pass++;
            else $display("FAIL %s event: got %0h want %0h", name, {k, p}, want);
        end
    endtask

    always @(negedge clk) begin
        if (in_token)     observe(K_IN,   {8'd0, in_endp}, "in_token");
        if (in_ack)       observe(K_ACK,  12'd0, "in_ack");
        if (out_token)    observe(K_OUT,  {7'd0, out_setup, out_endp}, "out_token");
        if (out_data_put) observe(K_DATA, {4'd0, out_data}, "out_data_put");
        if (out_pkt_end)  observe(K_END,  {10'd0, out_pkt_valid, out_data_pid}, "out_pkt_end");
        if (timeout)      observe(K_TMO,  {11'd0, out_setup}, "timeout");
        if (sof)          observe(K_SOF,  {1'b0, frame_num}, "sof");
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pkt_start();
        rx_pkt_start = 1'b1;
        tick();
        rx_pkt_start = 1'b0;
    endtask

    task automatic pkt_end(input logic [3:0] pid, input logic valid);
        rx_pid = pid;
        rx_pkt_valid = valid;
        rx_pkt_end = 1'b1;
        tick();
        rx_pkt_end = 1'b0;
        rx_pkt_valid = 1'b0;
    endtask

    task automatic put_byte(input logic [7:0] b);
        rx_data_put = 1'b1;
        rx_data = b;
        tick();
        rx_data_put = 1'b0;
    endtask

    task automatic send_token(input logic [3:0] pid, input logic [6:0] addr,
                              input logic [3:0] endp, input logic [10:0] frame);
        pkt_start();
        tick();
        rx_addr = addr;
        rx_endp = endp;
        rx_frame_num = frame;
        pkt_end(pid, 1'b1);
    endtask

    initial begin
        reset = 1'b1;
        dev_addr = 7'd5;
        rx_pkt_start = 1'b0;
        rx_pkt_end = 1'b0;
        rx_pkt_valid = 1'b0;
        rx_pid = 4'd0;
        rx_addr = 7'd0;
        rx_endp = 4'd0;
        rx_frame_num = 11'd0;
        rx_data_put = 1'b0;
        rx_data = 8'd0;
        repeat (3) tick();
        chk("reset_outputs", all_out(), 64'd0);
        reset = 1'b0;
        tick();

        // OUT endp 2 + DATA1 {11,22}
        expect_ev(K_OUT, 12'h002);
        send_token(PID_OUT, 7'd5, 4'd2, 11'd0);
        chk("out_endp_2", {60'd0, out_endp}, 64'd2);
        expect_ev(K_DATA, 12'h011);
        expect_ev(K_DATA, 12'h022);
        expect_ev(K_END, 12'h003);
        pkt_start();
        put_byte(8'h11);
        put_byte(8'h22);
        pkt_end(PID_DATA1, 1'b1);
        chk("out_data_pid_1", {63'd0, out_data_pid}, 64'd1);

        // Wrong address, then stray data in IDLE
        send_token(PID_OUT, 7'd6, 4'd3, 11'd0);
        pkt_start();
        put_byte(8'hEE);
        pkt_end(PID_DATA0, 1'b1);
        put_byte(8'hEF);

        // IN endp 1 then ACK
        expect_ev(K_IN, 12'h001);
        send_token(PID_IN, 7'd5, 4'd1, 11'd0);
        chk("in_endp_1", {60'd0, in_endp}, 64'd1);
        expect_ev(K_ACK, 12'h000);
        pkt_start();
        pkt_end(PID_ACK, 1'b1);
        chk("in_ack_latency", {63'd0, in_ack}, 64'd1);

        // IN endp 3 then NAK: no ack
        expect_ev(K_IN, 12'h003);
        send_token(PID_IN, 7'd5, 4'd3, 11'd0);
        pkt_start();
        pkt_end(PID_NAK, 1'b1);
        tick();

        // SETUP then silence until timeout
        expect_ev(K_OUT, 12'h010);
        send_token(PID_SETUP, 7'd5, 4'd0, 11'd0);
        expect_ev(K_TMO, 12'h001);
        repeat (511) tick();
        chk("timeout_not_early", {63'd0, timeout}, 64'd0);
        tick();
        chk("timeout_at_512", {63'd0, timeout}, 64'd1);
        chk("out_setup_kept", {63'd0, out_setup}, 64'd1);
        pkt_start();
        put_byte(8'h66);
        pkt_end(PID_DATA0, 1'b1);

        // DATA0 with bad CRC
        expect_ev(K_OUT, 12'h004);
        send_token(PID_OUT, 7'd5, 4'd4, 11'd0);
        expect_ev(K_DATA, 12'h05A);
        expect_ev(K_END, 12'h000);
        pkt_start();
        put_byte(8'h5A);
        pkt_end(PID_DATA0, 1'b0);

        // Restarted packet inside DATA
        expect_ev(K_OUT, 12'h001);
        send_token(PID_OUT, 7'd5, 4'd1, 11'd0);
        expect_ev(K_DATA, 12'h033);
        expect_ev(K_END, 12'h000);
        expect_ev(K_DATA, 12'h044);
        expect_ev(K_END, 12'h003);
        pkt_start();
        put_byte(8'h33);
        pkt_start();
        put_byte(8'h44);
        pkt_end(PID_DATA1, 1'b1);

        // Reset in the middle of a data packet
        expect_ev(K_OUT, 12'h007);
        send_token(PID_OUT, 7'd5, 4'd7, 11'd0);
        expect_ev(K_DATA, 12'h0A5);
        pkt_start();
        put_byte(8'hA5);
        reset = 1'b1;
        rx_data_put = 1'b1;
        rx_data = 8'hC3;
        tick();
        chk("reset_mid_data", all_out(), 64'd0);
        reset = 1'b0;
        rx_data_put = 1'b0;
        put_byte(8'h99);
        pkt_end(PID_DATA1, 1'b1);
        expect_ev(K_OUT, 12'h002);
        send_token(PID_OUT, 7'd5, 4'd2, 11'd0);
        expect_ev(K_DATA, 12'h077);
        expect_ev(K_END, 12'h003);
        pkt_start();
        put_byte(8'h77);
        pkt_end(PID_DATA1, 1'b1);

        // SOF while waiting for a handshake
        expect_ev(K_IN, 12'h006);
        send_token(PID_IN, 7'd5, 4'd6, 11'd0);
`ifdef USB_RX_ROUTER_SOF_EN
        expect_ev(K_SOF, 12'h3A5);
        send_token(PID_SOF, 7'd0, 4'd0, 11'h3A5);
        chk("frame_num_3a5", {53'd0, frame_num}, 64'h3A5);
`else
        send_token(PID_SOF, 7'd0, 4'd0, 11'h3A5);
        chk("sof_tied_off", {52'd0, sof, frame_num}, 64'd0);
`endif
        expect_ev(K_ACK, 12'h000);
        pkt_start();
        pkt_end(PID_ACK, 1'b1);

        repeat (5) tick();
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
